// File: rtl/e1_rx_mode_ctrl.sv
// ---------------------------------------------------------------------------
// e1_rx_mode_ctrl
//   Supervisor for the E1 RX deframer. It chooses between CRC-4 multiframe
//   and non-CRC-4 framing, and drives the deframer mode and reset inputs.
//   In auto mode it tries CRC-4 multiframe alignment first. If that fails
//   for TIMEOUT_MS it falls back to non-CRC-4, following G.706 Annex B
//   interworking. It also keeps saturating error counters that can be
//   snapshotted for the status layer.
//
//   Optional feature macro: E1_RX_CRC_RATE_MON_EN
//     When it is defined, a CRC error-rate monitor runs while in LOCK_MF.
//     If a window of WINDOW_MS ticks sees more than CRC_LIMIT CRC errors,
//     the block forces a CRC-4 realignment and pulses the deframer reset.
//     When it is undefined, stat_crc_excess_o is always 0.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   cfg_mode_i[1:0]       00/11 auto, 01 force non-CRC-4, 10 force CRC-4
//   tick_ms_i             1-cycle strobe per millisecond
//   df_aligned_i          deframer aligned status
//   df_err_*_i            deframer error pulses (crc, mfa, fas, nfas)
//   df_mode_mf_o          deframer multiframe-mode control
//   df_rst_o              deframer reset pulse (one cycle per mode change)
//   stat_lock_o           locked (LOCK_MF or LOCK_NOMF)
//   stat_crc4_o           locked in CRC-4 multiframe mode
//   stat_fallback_o       auto mode fell back to non-CRC-4 (sticky)
//   stat_snap_i           latch live counters into stat_cnt_*_o and clear them
//   stat_cnt_{crc,mfa,fas}_o  snapshot counters (fas includes nfas)
//   stat_crc_excess_o     1-cycle pulse on CRC rate violation
// ---------------------------------------------------------------------------
module e1_rx_mode_ctrl #(
  parameter int unsigned TIMEOUT_MS = 400,
  parameter int unsigned CNT_W      = 16
`ifdef E1_RX_CRC_RATE_MON_EN
  ,
  parameter int unsigned WINDOW_MS  = 1000,
  parameter int unsigned CRC_LIMIT  = 914
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       cfg_mode_i,
  input  logic             tick_ms_i,
  input  logic             df_aligned_i,
  input  logic             df_err_crc_i,
  input  logic             df_err_mfa_i,
  input  logic             df_err_fas_i,
  input  logic             df_err_nfas_i,
  output logic             df_mode_mf_o,
  output logic             df_rst_o,
  output logic             stat_lock_o,
  output logic             stat_crc4_o,
  output logic             stat_fallback_o,
  input  logic             stat_snap_i,
  output logic [CNT_W-1:0] stat_cnt_crc_o,
  output logic [CNT_W-1:0] stat_cnt_mfa_o,
  output logic [CNT_W-1:0] stat_cnt_fas_o,
  output logic             stat_crc_excess_o
);

  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_TRY_MF    = 3'd1,
    S_LOCK_MF   = 3'd2,
    S_TRY_NOMF  = 3'd3,
    S_LOCK_NOMF = 3'd4
  } state_e;

  localparam int unsigned TMR_W = $clog2(TIMEOUT_MS + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_MS - 1);

  // The deframer runs in multiframe mode in every CRC-4 state, and also in INIT.
  function automatic logic mode_mf(input state_e s);
    return (s == S_INIT) || (s == S_TRY_MF) || (s == S_LOCK_MF);
  endfunction

  // Saturating add of 0..2 events to a counter.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    if (sum[CNT_W]) begin
      return {CNT_W{1'b1}};
    end else begin
      return sum[CNT_W-1:0];
    end
  endfunction

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [1:0]        ign_q, ign_d;
  logic              df_mode_mf_q, df_rst_q;
  logic              stat_lock_q, stat_crc4_q, stat_fallback_q, stat_fallback_d;
  logic              stat_crc_excess_q;
  logic [CNT_W-1:0]  live_crc_q, live_mfa_q, live_fas_q;
  logic [CNT_W-1:0]  snap_crc_q, snap_mfa_q, snap_fas_q;
  logic [CNT_W-1:0]  add_crc_s, add_mfa_s, add_fas_s;

  logic force_nomf_s, force_mf_s;
  logic align_ok_s, lock_ok_s, drop_s, timeout_s;
  logic restart_s, set_fb_s, force_rst_s, excess_s;
  logic crc_excess_s;

  assign force_nomf_s = (cfg_mode_i == 2'b01);
  assign force_mf_s   = (cfg_mode_i == 2'b10);

  // While df_rst is high, and for two cycles after it, the deframer status is stale.
  assign align_ok_s = !df_rst_q && (ign_q == 2'd0);
  assign lock_ok_s  = df_aligned_i && align_ok_s;
  assign drop_s     = !df_aligned_i && align_ok_s;
  assign timeout_s  = tick_ms_i && (timer_q == TMR_LAST);

`ifdef E1_RX_CRC_RATE_MON_EN
  localparam int unsigned WIN_W  = $clog2(WINDOW_MS + 1);
  localparam int unsigned WCNT_W = $clog2(CRC_LIMIT + 2);
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW_MS - 1);
  localparam logic [WCNT_W:0]   LIMIT_V  = (WCNT_W + 1)'(CRC_LIMIT);

  logic [WIN_W-1:0]  win_tmr_q;
  logic [WCNT_W-1:0] win_cnt_q;
  logic              win_end_s;
  logic [WCNT_W:0]   win_total_s;

  assign win_end_s    = (state_q == S_LOCK_MF) && tick_ms_i && (win_tmr_q == WIN_LAST);
  // An error that coincides with the window end still counts in that window.
  assign win_total_s  = {1'b0, win_cnt_q} + {{WCNT_W{1'b0}}, df_err_crc_i};
  assign crc_excess_s = win_end_s && (win_total_s > LIMIT_V);

  // Window timer and CRC counter; only live while in LOCK_MF.
  always_ff @(posedge clk_i) begin
    if (rst_i || (state_q != S_LOCK_MF) || win_end_s) begin
      win_tmr_q <= '0;
      win_cnt_q <= '0;
    end else begin
      if (tick_ms_i) begin
        win_tmr_q <= win_tmr_q + WIN_W'(1);
      end
      if (df_err_crc_i && (win_cnt_q != {WCNT_W{1'b1}})) begin
        win_cnt_q <= win_cnt_q + WCNT_W'(1);
      end
    end
  end
`else
  assign crc_excess_s = 1'b0;
`endif

  // Next-state logic. Forced-mode mismatch wins, then lock/drop, then timeout.
  always_comb begin
    state_d     = state_q;
    restart_s   = 1'b0;
    set_fb_s    = 1'b0;
    force_rst_s = 1'b0;
    excess_s    = 1'b0;
    case (state_q)
      S_INIT: begin
        if (force_nomf_s) begin
          state_d = S_TRY_NOMF;
        end else begin
          state_d = S_TRY_MF;
        end
      end
      S_TRY_MF: begin
        if (force_nomf_s) begin
          state_d = S_TRY_NOMF;
        end else if (lock_ok_s) begin
          state_d = S_LOCK_MF;
        end else if (timeout_s) begin
          if (force_mf_s) begin
            restart_s = 1'b1;
          end else begin
            state_d  = S_TRY_NOMF;
            set_fb_s = 1'b1;
          end
        end else begin
          state_d = S_TRY_MF;
        end
      end
      S_LOCK_MF: begin
        if (force_nomf_s) begin
          state_d = S_TRY_NOMF;
        end else if (crc_excess_s) begin
          // The mode is unchanged, but the deframer still gets a reset.
          state_d     = S_TRY_MF;
          force_rst_s = 1'b1;
          excess_s    = 1'b1;
        end else if (drop_s) begin
          state_d = S_TRY_MF;
        end else begin
          state_d = S_LOCK_MF;
        end
      end
      S_TRY_NOMF: begin
        if (force_mf_s) begin
          state_d = S_TRY_MF;
        end else if (lock_ok_s) begin
          state_d = S_LOCK_NOMF;
        end else if (timeout_s) begin
          if (force_nomf_s) begin
            restart_s = 1'b1;
          end else begin
            state_d = S_TRY_MF;
          end
        end else begin
          state_d = S_TRY_NOMF;
        end
      end
      S_LOCK_NOMF: begin
        if (force_mf_s) begin
          state_d = S_TRY_MF;
        end else if (drop_s) begin
          if (force_nomf_s) begin
            state_d = S_TRY_NOMF;
          end else begin
            state_d = S_TRY_MF;
          end
        end else begin
          state_d = S_LOCK_NOMF;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // TRY timer, fallback flag, and status-ignore countdown next values.
  always_comb begin
    timer_d         = timer_q;
    stat_fallback_d = stat_fallback_q;
    ign_d           = ign_q;
    if ((state_d != state_q) || restart_s) begin
      timer_d = '0;
    end else if (tick_ms_i && ((state_q == S_TRY_MF) || (state_q == S_TRY_NOMF))) begin
      timer_d = timer_q + TMR_W'(1);
    end else begin
      timer_d = timer_q;
    end
    if (state_d == S_LOCK_MF) begin
      stat_fallback_d = 1'b0;
    end else if (set_fb_s) begin
      stat_fallback_d = 1'b1;
    end else begin
      stat_fallback_d = stat_fallback_q;
    end
    if (df_rst_q) begin
      ign_d = 2'd2;
    end else if (ign_q != 2'd0) begin
      ign_d = ign_q - 2'd1;
    end else begin
      ign_d = 2'd0;
    end
  end

  // State, timer, and registered status outputs derived from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q           <= S_INIT;
      timer_q           <= '0;
      ign_q             <= 2'd0;
      df_mode_mf_q      <= 1'b1;
      df_rst_q          <= 1'b1;
      stat_lock_q       <= 1'b0;
      stat_crc4_q       <= 1'b0;
      stat_fallback_q   <= 1'b0;
      stat_crc_excess_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      timer_q           <= timer_d;
      ign_q             <= ign_d;
      df_mode_mf_q      <= mode_mf(state_d);
      // Reset the deframer exactly when its mode input changes, or when forced.
      df_rst_q          <= (mode_mf(state_d) != df_mode_mf_q) || force_rst_s;
      stat_lock_q       <= (state_d == S_LOCK_MF) || (state_d == S_LOCK_NOMF);
      stat_crc4_q       <= (state_d == S_LOCK_MF);
      stat_fallback_q   <= stat_fallback_d;
      stat_crc_excess_q <= excess_s;
    end
  end

  assign add_crc_s = sat_add(live_crc_q, {1'b0, df_err_crc_i});
  assign add_mfa_s = sat_add(live_mfa_q, {1'b0, df_err_mfa_i});
  assign add_fas_s = sat_add(live_fas_q, {1'b0, df_err_fas_i} + {1'b0, df_err_nfas_i});

  // Live and snapshot error counters; a snap also captures events in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      live_crc_q <= '0;
      live_mfa_q <= '0;
      live_fas_q <= '0;
      snap_crc_q <= '0;
      snap_mfa_q <= '0;
      snap_fas_q <= '0;
    end else if (stat_snap_i) begin
      snap_crc_q <= add_crc_s;
      snap_mfa_q <= add_mfa_s;
      snap_fas_q <= add_fas_s;
      live_crc_q <= '0;
      live_mfa_q <= '0;
      live_fas_q <= '0;
    end else begin
      live_crc_q <= add_crc_s;
      live_mfa_q <= add_mfa_s;
      live_fas_q <= add_fas_s;
    end
  end

  assign df_mode_mf_o      = df_mode_mf_q;
  assign df_rst_o          = df_rst_q;
  assign stat_lock_o       = stat_lock_q;
  assign stat_crc4_o       = stat_crc4_q;
  assign stat_fallback_o   = stat_fallback_q;
  assign stat_crc_excess_o = stat_crc_excess_q;
  assign stat_cnt_crc_o    = snap_crc_q;
  assign stat_cnt_mfa_o    = snap_mfa_q;
  assign stat_cnt_fas_o    = snap_fas_q;

endmodule
